// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and the alignment rule for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Halves need an even byte address, words need a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_H, F3_HU: misaligned = lane[0];
      F3_W:        misaligned = (lane != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data/byte-enables from funct3+lane, and extended load data from a raw word.
// Purely combinational, zero latency, no flow control of its own.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wbe,
  output logic [31:0] wword,
  output logic        st_err,
  output logic [31:0] rdata,
  output logic        ld_err
);

  logic [31:0] shifted;
  logic        bad_align;

  assign bad_align = misaligned(funct3, lane);
  assign shifted   = rword >> {lane, 3'b000};

  always_comb begin
    wbe    = 4'b0000;
    st_err = 1'b0;
    wword  = wdata << {lane, 3'b000};
    case (funct3)
      F3_B:    wbe = 4'b0001 << lane;
      F3_H:    wbe = 4'b0011 << lane;
      F3_W:    wbe = 4'b1111;
      default: st_err = 1'b1;
    endcase
    if (bad_align) begin
      st_err = 1'b1;
    end
    if (st_err) begin
      wbe = 4'b0000;
    end
  end

  always_comb begin
    rdata  = '0;
    ld_err = bad_align;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = shifted;
      F3_BU:   rdata = {24'h000000, shifted[7:0]};
      F3_HU:   rdata = {16'h0000, shifted[15:0]};
      default: ld_err = 1'b1;
    endcase
    if (ld_err) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one outstanding request, rsp_valid LATENCY cycles after accept.
// Response is held stable until rsp_ready; req_ready stays low from accept until the response handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, access;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_funct3;
  logic [31:0]       cap_wdata;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_funct3;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] widx;

  logic [31:0]       mem [NUM_WORDS];

  logic [3:0]        wbe;
  logic [31:0]       wword;
  logic              st_err;
  logic [31:0]       ld_rdata;
  logic              ld_err;

  // req_ready is high exactly while the FSM sits in IDLE.
  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accepting edge, so it must see the live request.
  always_comb begin
    acc_we     = cap_we;
    acc_addr   = cap_addr;
    acc_funct3 = cap_funct3;
    acc_wdata  = cap_wdata;
    if (state == IDLE) begin
      acc_we     = req_we;
      acc_addr   = req_addr;
      acc_funct3 = req_funct3;
      acc_wdata  = req_wdata;
    end
  end

  assign widx = acc_addr[ADDR_W-1:2];

  dmem_lane_align u_align (
    .funct3 (acc_funct3),
    .lane   (acc_addr[1:0]),
    .wdata  (acc_wdata),
    .rword  (mem[widx]),
    .wbe    (wbe),
    .wword  (wword),
    .st_err (st_err),
    .rdata  (ld_rdata),
    .ld_err (ld_err)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        cap_we     <= req_we;
        cap_addr   <= req_addr;
        cap_funct3 <= req_funct3;
        cap_wdata  <= req_wdata;
      end
      if (access) begin
        rsp_rdata <= acc_we ? 32'h0 : ld_rdata;
        rsp_err   <= acc_we ? st_err : ld_err;
        for (int b = 0; b < 4; b++) begin
          if (acc_we && wbe[b]) begin
            mem[widx][8*b +: 8] <= wword[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
